// File: rtl/tconv_layer_input_scheduler.sv
// rtl/tconv_layer_input_scheduler.sv - paces one raster frame of pixels into a transposed-conv layer
// Optional output counter: define TCONV_SCHED_OUT_COUNT_EN
module tconv_layer_input_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int IN_WIDTH     = 13,
    parameter int IN_HEIGHT    = 13,
    parameter int PIX_GAP      = 5,
    parameter int ROW_GAP      = 100,
    parameter int FLUSH_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_last_col,
    output logic                  pix_last_row,
    input  logic                  layer_valid_out,
    output logic                  busy,
    output logic                  done
`ifdef TCONV_SCHED_OUT_COUNT_EN
    ,
    output logic [31:0]           out_cnt
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(max2(IN_WIDTH, IN_HEIGHT), max2(PIX_GAP, ROW_GAP)), FLUSH_CYCLES);
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(IN_HEIGHT - 1);
    localparam logic [CW-1:0] PGAP_LOAD  = CW'(PIX_GAP - 1);
    localparam logic [CW-1:0] RGAP_LOAD  = CW'(ROW_GAP - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PGAP  = 3'd2;
    localparam logic [2:0] S_RGAP  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         col_q, col_d, row_q, row_d, gap_q, gap_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                  last_col_q, last_col_d, last_row_q, last_row_d;
    logic                  busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        gap_d       = gap_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        last_col_d  = 1'b0;
        last_row_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle is spent in IDLE; start is only honoured once it has passed.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    state_d = S_FETCH;
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = in_data;
                    last_col_d  = (col_q == COL_LAST);
                    last_row_d  = (row_q == ROW_LAST);
                    if (col_q != COL_LAST) begin
                        state_d = S_PGAP;
                        col_d   = col_q + 1'b1;
                        gap_d   = PGAP_LOAD;
                    end else if (row_q != ROW_LAST) begin
                        state_d = S_RGAP;
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                        gap_d   = RGAP_LOAD;
                    end else begin
                        state_d = S_FLUSH;
                        gap_d   = FLUSH_LOAD;
                    end
                end
            end
            S_PGAP, S_RGAP: begin
                if (gap_q == '0) state_d = S_FETCH;
                else             gap_d   = gap_q - 1'b1;
            end
            S_FLUSH: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            gap_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            last_col_q  <= 1'b0;
            last_row_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            last_col_q  <= last_col_d;
            last_row_q  <= last_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready     = (state_q == S_FETCH);
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign pix_last_col = last_col_q;
    assign pix_last_row = last_row_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef TCONV_SCHED_OUT_COUNT_EN
    logic [31:0] out_cnt_q;

    // Frozen on the done cycle so the total stays readable until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q <= '0;
        end else if (state_q == S_IDLE && !done_q && start) begin
            out_cnt_q <= '0;
        end else if (busy_q && !done_q && layer_valid_out) begin
            out_cnt_q <= out_cnt_q + 32'd1;
        end
    end

    assign out_cnt = out_cnt_q;
`else
    logic unused_layer_valid_out;
    assign unused_layer_valid_out = layer_valid_out;
`endif

endmodule

// File: tb/tb_tconv_layer_input_scheduler.sv
// tb/tb_tconv_layer_input_scheduler.sv - directed bench for tconv_layer_input_scheduler
module tb_tconv_layer_input_scheduler;

    localparam int W     = 13;
    localparam int H     = 13;
    localparam int PGAP  = 5;
    localparam int RGAP  = 100;
    localparam int FLUSH = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, pix_valid, plc, plr, busy, done;
    logic [15:0] pix_data;
    logic        start1 = 1'b0, in_valid1 = 1'b0;
    logic [15:0] in_data1 = '0;
    logic        in_ready1, pix_valid1, plc1, plr1, busy1, done1;
    logic [15:0] pix_data1;
    logic        lvo = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tconv_layer_input_scheduler #(
        .DATA_WIDTH(16), .IN_WIDTH(W), .IN_HEIGHT(H),
        .PIX_GAP(PGAP), .ROW_GAP(RGAP), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_last_col(plc), .pix_last_row(plr), .layer_valid_out(lvo),
        .busy(busy), .done(done)
    );

    tconv_layer_input_scheduler #(
        .DATA_WIDTH(16), .IN_WIDTH(1), .IN_HEIGHT(1),
        .PIX_GAP(5), .ROW_GAP(100), .FLUSH_CYCLES(3)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .pix_valid(pix_valid1), .pix_data(pix_data1),
        .pix_last_col(plc1), .pix_last_row(plr1), .layer_valid_out(lvo),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_last_col"}, plc, 0);
        chk({tag, "_last_row"}, plr, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    typedef struct {
        int duty;
        bit exact;
        int abort_at;
    } frame_t;

    typedef struct {
        logic        st, iv;
        logic        rdy, pv, dn, bz;
        logic [15:0] dat;
    } step_t;

    function automatic step_t mk(input logic st, input logic iv, input logic rdy,
                                 input logic pv, input logic dn, input logic bz,
                                 input logic [15:0] dat);
        step_t s;
        s.st = st; s.iv = iv; s.rdy = rdy; s.pv = pv; s.dn = dn; s.bz = bz; s.dat = dat;
        return s;
    endfunction

    // Each loop iteration observes outputs at a negedge, then drives the inputs for the next edge.
    task automatic run_frame(input frame_t f);
        int  acc = 0, pulses = 0, blk = 0, last_pulse = -1, final_c = -1, exp_sp;
        bit  acc_prev = 0, fetching = 1, seen_done = 0, finished = 0, aborted = 0;
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            chk("pix_valid_latency", pix_valid, acc_prev);
            if (pix_valid) begin
                chk("pix_data_order", pix_data, pulses);
                chk("pix_last_col", plc, (pulses % W) == W - 1);
                chk("pix_last_row", plr, pulses >= W * (H - 1));
                if (last_pulse >= 0) begin
                    exp_sp = ((pulses % W) == 0) ? RGAP + 1 : PGAP + 1;
                    if (f.exact) chk("spacing", c - last_pulse, exp_sp);
                    else         chk("spacing_min", (c - last_pulse) >= exp_sp, 1);
                end
                last_pulse = c;
                pulses++;
            end
            chk("in_ready", in_ready, fetching && blk == 0);
            chk("done_time", done, final_c >= 0 && c == final_c + FLUSH + 1);
            if (seen_done) begin
                chk("busy_after_done", busy, 0);
                finished = 1;
            end else begin
                chk("busy_in_frame", busy, 1);
            end
            if (done) seen_done = 1;
            if (f.abort_at > 0 && pulses == f.abort_at && !finished) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                chk_zero("after_mid_reset");
                rst = 1'b0;
                finished = 1;
                aborted = 1;
            end else begin
                if (blk > 0) blk--;
                in_valid = ($urandom_range(99) < f.duty);
                in_data = acc[15:0];
                acc_prev = in_ready && in_valid;
                if (acc_prev) begin
                    if ((acc % W) != W - 1)      blk = PGAP;
                    else if ((acc / W) != H - 1) blk = RGAP;
                    else begin
                        fetching = 0;
                        final_c = c;
                    end
                    acc++;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!finished) chk("frame_timeout", 0, 1);
        if (!aborted) chk("pulse_count", pulses, W * H);
    endtask

    frame_t frames[4];
    step_t  steps[14];

    initial begin
        frames[0] = '{duty: 100, exact: 1'b1, abort_at: 0};
        frames[1] = '{duty: 30,  exact: 1'b0, abort_at: 0};
        frames[2] = '{duty: 100, exact: 1'b1, abort_at: 40};
        frames[3] = '{duty: 100, exact: 1'b1, abort_at: 0};

        // start held through the done cycle on a 1x1 frame with a 3-cycle flush
        steps[0]  = mk(1, 1, 0, 0, 0, 0, 16'h0000);
        steps[1]  = mk(1, 1, 1, 0, 0, 1, 16'h0000);
        steps[2]  = mk(1, 1, 0, 1, 0, 1, 16'h1001);
        steps[3]  = mk(1, 1, 0, 0, 0, 1, 16'h0000);
        steps[4]  = mk(1, 1, 0, 0, 0, 1, 16'h0000);
        steps[5]  = mk(1, 1, 0, 0, 1, 1, 16'h0000);
        steps[6]  = mk(1, 1, 0, 0, 0, 0, 16'h0000);
        steps[7]  = mk(1, 1, 1, 0, 0, 1, 16'h0000);
        steps[8]  = mk(0, 1, 0, 1, 0, 1, 16'h1007);
        steps[9]  = mk(0, 0, 0, 0, 0, 1, 16'h0000);
        steps[10] = mk(0, 0, 0, 0, 0, 1, 16'h0000);
        steps[11] = mk(0, 0, 0, 0, 1, 1, 16'h0000);
        steps[12] = mk(0, 0, 0, 0, 0, 0, 16'h0000);
        steps[13] = mk(0, 0, 0, 0, 0, 0, 16'h0000);

        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_dut1_busy", busy1, 0);
        chk("reset_dut1_ready", in_ready1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < 4; i++) run_frame(frames[i]);

        for (int i = 0; i < 14; i++) begin
            chk("t5_in_ready", in_ready1, steps[i].rdy);
            chk("t5_pix_valid", pix_valid1, steps[i].pv);
            chk("t5_done", done1, steps[i].dn);
            chk("t5_busy", busy1, steps[i].bz);
            if (steps[i].pv) begin
                chk("t5_pix_data", pix_data1, steps[i].dat);
                chk("t5_last_col", plc1, 1);
                chk("t5_last_row", plr1, 1);
            end
            start1 = steps[i].st;
            in_valid1 = steps[i].iv;
            in_data1 = 16'h1000 + 16'(i);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
